// File: rtl/round_ctrl.sv
// round_ctrl: connect-4 round sequencer (board clear, turn tracking, score pulses, result hold).
// Optional feature macro MATCH_LIMIT_EN: per-player round tallies end the match at WIN_TARGET wins.
module round_ctrl #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int WIN_TARGET  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_done,
  input  logic       win1,
  input  logic       win2,
  input  logic       draw,
  input  logic       next_round,
  output logic       inc1,
  output logic       inc2,
  output logic       board_clr,
  output logic       turn,
  output logic [2:0] state,
  output logic       match_over
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_PLAY       = 3'd2,
    ST_SCORE      = 3'd3,
    ST_HOLD       = 3'd4,
    ST_WAIT_NEXT  = 3'd5,
    ST_MATCH_OVER = 3'd6
  } state_t;

  localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_r;
  logic             inc1_r;
  logic             inc2_r;
  logic             board_clr_r;
  logic             turn_r;
  logic             first_player_r;
  logic             winner_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic             tie_s;
  logic             hold_done_s;

  // A double connect-4 is scored like a draw: nobody gets the point.
  assign tie_s       = (win1 & win2) | draw;
  assign hold_done_s = (hold_cnt_r == HOLD_LAST);

`ifdef MATCH_LIMIT_EN
  logic [6:0] wins1_r;
  logic [6:0] wins2_r;
  logic [6:0] tally_inc_s;
  logic       target_hit_s;
  logic       match_over_r;

  assign tally_inc_s  = (winner_r ? wins2_r : wins1_r) + 7'd1;
  assign target_hit_s = (tally_inc_s == 7'(WIN_TARGET));
  assign match_over   = match_over_r;
`else
  localparam int UNUSED_WIN_TARGET = WIN_TARGET;
  logic unused_winner_s;

  assign unused_winner_s = winner_r;
  assign match_over      = 1'b0;
`endif

  // Round/match sequencing; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      inc1_r         <= 1'b0;
      inc2_r         <= 1'b0;
      board_clr_r    <= 1'b0;
      turn_r         <= 1'b0;
      first_player_r <= 1'b0;
      winner_r       <= 1'b0;
      hold_cnt_r     <= {CNT_W{1'b0}};
`ifdef MATCH_LIMIT_EN
      wins1_r        <= 7'd0;
      wins2_r        <= 7'd0;
      match_over_r   <= 1'b0;
`endif
    end else begin
      inc1_r      <= 1'b0;
      inc2_r      <= 1'b0;
      board_clr_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_CLEAR;
            board_clr_r <= 1'b1;
          end
        end
        ST_CLEAR: begin
          turn_r  <= first_player_r;
          state_r <= ST_PLAY;
        end
        ST_PLAY: begin
          if (tie_s) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= {CNT_W{1'b0}};
          end else if (win1) begin
            state_r  <= ST_SCORE;
            winner_r <= 1'b0;
            inc1_r   <= 1'b1;
          end else if (win2) begin
            state_r  <= ST_SCORE;
            winner_r <= 1'b1;
            inc2_r   <= 1'b1;
          end else if (move_done) begin
            turn_r <= ~turn_r;
          end
        end
        ST_SCORE: begin
`ifdef MATCH_LIMIT_EN
          if (winner_r) begin
            wins2_r <= tally_inc_s;
          end else begin
            wins1_r <= tally_inc_s;
          end
          if (target_hit_s) begin
            state_r      <= ST_MATCH_OVER;
            match_over_r <= 1'b1;
          end else begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= {CNT_W{1'b0}};
          end
`else
          state_r    <= ST_HOLD;
          hold_cnt_r <= {CNT_W{1'b0}};
`endif
        end
        ST_HOLD: begin
          if (hold_done_s) begin
            state_r <= ST_WAIT_NEXT;
          end else begin
            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_NEXT: begin
          // Starters alternate from round to round.
          if (next_round) begin
            state_r        <= ST_CLEAR;
            board_clr_r    <= 1'b1;
            first_player_r <= ~first_player_r;
          end
        end
`ifdef MATCH_LIMIT_EN
        ST_MATCH_OVER: begin
          if (start) begin
            state_r        <= ST_CLEAR;
            board_clr_r    <= 1'b1;
            first_player_r <= 1'b0;
            wins1_r        <= 7'd0;
            wins2_r        <= 7'd0;
            match_over_r   <= 1'b0;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign inc1      = inc1_r;
  assign inc2      = inc2_r;
  assign board_clr = board_clr_r;
  assign turn      = turn_r;
  assign state     = state_r;

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: randomized rounds against an event-level match model; a monitor
// turns DUT output activity into events and checks them against a scoreboard queue.
module tb_round_ctrl;
  localparam int HOLD   = 4;
  localparam int TARGET = 2;
`ifdef MATCH_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  localparam int K_CLR  = 0;
  localparam int K_TURN = 1;
  localparam int K_INC  = 2;
  localparam int K_HOLD = 3;
  localparam int K_OVER = 4;
  localparam int K_IDLE = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       move_done = 1'b0;
  logic       win1 = 1'b0;
  logic       win2 = 1'b0;
  logic       draw = 1'b0;
  logic       next_round = 1'b0;
  logic       inc1;
  logic       inc2;
  logic       board_clr;
  logic       turn;
  logic [2:0] state;
  logic       match_over;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int val;
  } exp_t;
  exp_t exp_q[$];

  // match model: who starts, whose move, round-win tallies
  bit m_first = 1'b0;
  bit m_turn  = 1'b0;
  bit m_over  = 1'b0;
  int m_w1 = 0;
  int m_w2 = 0;

  round_ctrl #(.HOLD_CYCLES(HOLD), .WIN_TARGET(TARGET)) dut (
    .clk(clk), .reset(reset), .start(start), .move_done(move_done),
    .win1(win1), .win2(win2), .draw(draw), .next_round(next_round),
    .inc1(inc1), .inc2(inc2), .board_clr(board_clr), .turn(turn),
    .state(state), .match_over(match_over)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_CLR:   return "board_clr";
      K_TURN:  return "turn";
      K_INC:   return "inc_pulse";
      K_HOLD:  return "hold_exit";
      K_OVER:  return "match_over";
      default: return "idle_outputs";
    endcase
  endfunction

  task automatic push(input int k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input int v);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got value %0d, no event expected", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        fails++;
        $display("FAIL %s: got %s=%0d, expected %s=%0d", kname(k), kname(k), v, kname(e.kind), e.val);
      end
    end
  endtask

  task automatic check_state(input string nm, input logic [2:0] exp_s);
    tests++;
    if (state !== exp_s) begin
      fails++;
      $display("FAIL %s: state=%0d expected %0d", nm, state, exp_s);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state == s) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_state: state=%0d expected %0d within %0d cycles", state, s, budget);
    end
  endtask

  // Monitor: every clear pulse, turn change, inc pulse, HOLD exit, MATCH_OVER or IDLE entry is an event.
  logic [2:0] prev_state = 3'd7;
  logic       prev_turn  = 1'b0;
  int         hold_len   = 0;
  always @(negedge clk) begin
    if (board_clr) observe(K_CLR, int'(state) * 2 + int'(match_over));
    if ((state == 3'd2 && prev_state != 3'd2) || turn != prev_turn) observe(K_TURN, int'(turn));
    if (inc1 | inc2) observe(K_INC, int'({state, inc2, inc1}));
    if (state == 3'd4) begin
      hold_len++;
    end else if (prev_state == 3'd4) begin
      observe(K_HOLD, hold_len * 16 + int'(state));
      hold_len = 0;
    end
    if (state == 3'd6 && prev_state != 3'd6) observe(K_OVER, int'(match_over));
    if (state == 3'd0 && prev_state != 3'd0) observe(K_IDLE, int'({inc1, inc2, board_clr, turn, match_over}));
    prev_state = state;
    prev_turn  = turn;
  end

  task automatic clear_inputs();
    start = 1'b0; move_done = 1'b0; win1 = 1'b0; win2 = 1'b0; draw = 1'b0; next_round = 1'b0;
  endtask

  task automatic begin_match();
    m_turn = m_first;
    push(K_CLR, 2);
    push(K_TURN, int'(m_turn));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(3'd2, 5);
  endtask

  // outcome: 0 win1, 1 win2, 2 both win, 3 draw; abort pulls reset in HOLD cycle 2
  task automatic play_round(input int nmoves, input int outcome, input bit mv_win, input bit abort);
    for (int i = 0; i < nmoves; i++) begin
      m_turn = ~m_turn;
      push(K_TURN, int'(m_turn));
      move_done  = 1'b1;
      start      = ($urandom_range(0, 3) == 0);
      next_round = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      clear_inputs();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    case (outcome)
      0:       win1 = 1'b1;
      1:       win2 = 1'b1;
      2:       begin win1 = 1'b1; win2 = 1'b1; end
      default: draw = 1'b1;
    endcase
    move_done = mv_win;
    m_over = 1'b0;
    if (outcome == 0) begin
      m_w1++;
      push(K_INC, 13);
      m_over = LIMIT && (m_w1 == TARGET);
    end else if (outcome == 1) begin
      m_w2++;
      push(K_INC, 14);
      m_over = LIMIT && (m_w2 == TARGET);
    end
    if (abort) begin
      if (m_turn) push(K_TURN, 0);
      push(K_HOLD, 2 * 16 + 0);
      push(K_IDLE, 0);
    end else if (m_over) begin
      push(K_OVER, 1);
    end else begin
      push(K_HOLD, HOLD * 16 + 5);
    end
    @(negedge clk);
    clear_inputs();
    if (abort) begin
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m_first = 1'b0; m_turn = 1'b0; m_over = 1'b0; m_w1 = 0; m_w2 = 0;
    end else begin
      for (int c = 0; c < 20; c++) begin
        if (state == 3'd3 || state == 3'd4) begin
          next_round = $urandom_range(0, 1);
          start      = $urandom_range(0, 1);
          move_done  = $urandom_range(0, 1);
          win1       = $urandom_range(0, 1);
          win2       = $urandom_range(0, 1);
          draw       = $urandom_range(0, 1);
          @(negedge clk);
        end else begin
          break;
        end
      end
      clear_inputs();
      check_state("round_end", m_over ? 3'd6 : 3'd5);
      if (m_over) begin
        next_round = 1'b1;
        @(negedge clk);
        next_round = 1'b0;
        repeat (2) @(negedge clk);
        check_state("over_ignores_next_round", 3'd6);
        m_w1 = 0; m_w2 = 0; m_first = 1'b0;
        begin_match();
      end else begin
        repeat ($urandom_range(0, 2)) begin
          start     = $urandom_range(0, 1);
          move_done = $urandom_range(0, 1);
          win1      = $urandom_range(0, 1);
          draw      = $urandom_range(0, 1);
          @(negedge clk);
        end
        clear_inputs();
        m_first = ~m_first;
        m_turn  = m_first;
        push(K_CLR, 2);
        push(K_TURN, int'(m_turn));
        next_round = 1'b1;
        @(negedge clk);
        next_round = 1'b0;
        wait_state(3'd2, 5);
      end
    end
  endtask

  initial begin
    push(K_IDLE, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_state("reset_state", 3'd0);
    win1 = 1'b1; move_done = 1'b1; next_round = 1'b1; draw = 1'b1;
    repeat (3) @(negedge clk);
    clear_inputs();
    check_state("idle_ignores_inputs", 3'd0);
    begin_match();
    play_round(3, 1, 1'b0, 1'b0);   // turn 1,0,1 then player 2 wins
    play_round(0, 2, 1'b0, 1'b0);   // double connect-4: no point
    play_round(2, 0, 1'b1, 1'b0);   // move_done coincides with win1
    play_round(1, 0, 1'b0, 1'b0);   // player 1's second round win
    for (int r = 0; r < 14; r++) begin
      play_round($urandom_range(0, 5), $urandom_range(0, 3), ($urandom_range(0, 2) == 0), 1'b0);
    end
    play_round(1, 2, 1'b0, 1'b1);   // reset during HOLD
    win1 = 1'b1; move_done = 1'b1; next_round = 1'b1;
    repeat (5) @(negedge clk);
    clear_inputs();
    check_state("after_abort_idle", 3'd0);
    begin_match();
    play_round(2, 1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_events: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
